pwm_reg_bridge: RTL and testbench
=================================

// Module: pwm_reg_bridge
// PURPOSE
//  Bus initiator for the PWM register file: decodes command frames from a byte stream (UART RX side).
//  Issues single-cycle wr_en/rd_en register accesses.
//  Returns ACK, NAK or read-data bytes on an output byte stream (UART TX side).
//  Sits between the UART byte interfaces and the PWM register block.
// PARAMETERS
//  WIDTH        16     register data width; must be a multiple of 8 (NB = WIDTH/8 bytes per word)
//  TIMEOUT_CYC  50000  max clk cycles between frame bytes (used only with PWM_BRIDGE_TIMEOUT_EN)
// PORTS
//  clk       in   1      clock, single domain
//  rst_n     in   1      asynchronous active-low reset
//  rx_valid  in   1      command byte valid
//  rx_data   in   8      command byte
//  rx_ready  out  1      bridge accepts rx byte; transfer when rx_valid & rx_ready
//  tx_valid  out  1      response byte valid
//  tx_data   out  8      response byte
//  tx_ready  in   1      sink accepts tx byte; transfer when tx_valid & tx_ready
//  wr_en     out  1      register write strobe, 1 cycle
//  rd_en     out  1      register read strobe, 1 cycle
//  addr      out  4      register address
//  wr_data   out  WIDTH  register write data
//  rd_data   in   WIDTH  register read data, combinational from target while rd_en=1
//  busy      out  1      high whenever state != IDLE
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; shift register and counters cleared.
//  Header byte: bit7 = W (1 = write, 0 = read); bits6:4 must be 000; bits3:0 = addr.
//  State machine:
//  - IDLE: rx_ready=1; header accepted -> latch addr.
//    - Bad header (bits6:4 != 0) -> load NAK 0x5A, go to SEND with 1 byte.
//    - W=1 -> GET_DATA (byte cnt 0); W=0 -> READ.
//  - GET_DATA: rx_ready=1; accept NB bytes MSB first, shifted into wr_data; after byte NB-1 -> WRITE.
//  - WRITE: wr_en=1 for exactly one cycle, addr/wr_data stable; load ACK 0xA5 -> SEND, 1 byte.
//  - READ: rd_en=1 for exactly one cycle; rd_data captured at that edge; -> SEND, NB bytes MSB first.
//  - SEND: rx_ready=0; tx_valid=1 with tx_data = current byte.
//    - tx_data held stable until tx_ready.
//    - Each handshake advances the byte; after the last handshake -> IDLE.
//  Latency:
//  - Write: wr_en in the cycle after the last data byte handshake; tx_valid the cycle after that.
//  - Read: rd_en in the cycle after the header handshake; tx_valid the next cycle.
//  rx_ready is 0 in WRITE, READ and SEND; no rx byte is dropped, the source must hold it.
//  wr_en and rd_en are never high together and never high outside WRITE/READ.
//  addr and wr_data hold their last values between frames; no bus access without a complete frame.
//  rst_n asserted mid-frame: frame discarded, outputs to reset values asynchronously, no partial strobe.
// CONFIGURATION
//  PWM_BRIDGE_TIMEOUT_EN defined:
//  - An idle counter runs in GET_DATA and resets on each rx handshake.
//  - Reaching TIMEOUT_CYC -> abort the frame, no wr_en, send NAK 0x5A, then IDLE.
//  PWM_BRIDGE_TIMEOUT_EN undefined: GET_DATA waits indefinitely; no counter logic.
// STRUCTURE
//  Package pwm_bridge_pkg:
//  - state enum (IDLE, GET_DATA, WRITE, READ, SEND)
//  - constants RSP_ACK=8'hA5, RSP_NAK=8'h5A, HDR_W_BIT=7
//  One sub-module pwm_bridge_timer (load/clear/expire counter).
//  - Instantiated only under PWM_BRIDGE_TIMEOUT_EN.
// TESTING
//  1. Write: rx 0x84,0x12,0x34 -> one wr_en pulse with addr=4, wr_data=0x1234; tx 0xA5; then IDLE.
//  2. Read: rx 0x08, target rd_data=0xBEEF -> one rd_en pulse with addr=8; tx 0xBE then 0xEF.
//  3. tx backpressure: tx_ready=0 for 5 cycles during a read reply -> tx_data held, no byte lost or duplicated.
//  4. Bad header: rx 0x94 -> no wr_en/rd_en; tx 0x5A; next valid frame accepted normally.
//  5. Reset mid-frame: rst_n low after 0x84,0x12 -> all outputs 0; post-reset frame 0x80,0x00,0x03 writes 0x0003.
//  6. Timeout (PWM_BRIDGE_TIMEOUT_EN, TIMEOUT_CYC=20): rx 0x8C, 0xAA then a 25-cycle gap -> no wr_en; tx 0x5A.

Source files
------------

// File: rtl/pwm_bridge_pkg.sv
// Shared types and constants for the PWM register bridge.
//   state_e : bridge state machine encoding
//   RSP_ACK / RSP_NAK : response bytes returned on the TX stream
//   HDR_W_BIT : header bit selecting write (1) or read (0)
package pwm_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_DATA = 3'd1,
    WRITE    = 3'd2,
    READ     = 3'd3,
    SEND     = 3'd4
  } state_e;

  localparam logic [7:0]  RSP_ACK   = 8'hA5;
  localparam logic [7:0]  RSP_NAK   = 8'h5A;
  localparam int unsigned HDR_W_BIT = 7;

endpackage

// File: rtl/pwm_bridge_timer.sv
// Inter-byte idle timer for the bridge.
//   clk, rst_n : clock, async active-low reset
//   clear_i    : restart the count from zero (has priority)
//   run_i      : count one per cycle while high, saturating at TIMEOUT_CYC
//   expired_o  : registered flag, high once TIMEOUT_CYC idle cycles have elapsed
module pwm_bridge_timer #(
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic run_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expired_q, expired_d;

  // Next count and expiry flag
  always_comb begin
    cnt_d     = cnt_q;
    expired_d = 1'b0;
    if (clear_i) begin
      cnt_d = '0;
    end else if (run_i && (cnt_q != CNT_W'(TIMEOUT_CYC))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    expired_d = !clear_i && (cnt_d == CNT_W'(TIMEOUT_CYC));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= expired_d;
    end
  end

  assign expired_o = expired_q;

endmodule

// File: rtl/pwm_reg_bridge.sv
// Byte-stream to register-bus bridge for the PWM register file.
// Decodes header [W|000|addr] plus NB=WIDTH/8 data bytes (writes), issues a
// one-cycle wr_en/rd_en, and answers with ACK, NAK or NB read-data bytes.
//   clk, rst_n                 : clock, async active-low reset
//   rx_valid, rx_data, rx_ready: command byte stream in
//   tx_valid, tx_data, tx_ready: response byte stream out
//   wr_en, rd_en, addr, wr_data: register access strobes and payload
//   rd_data                    : combinational read data while rd_en=1
//   busy                       : high whenever the bridge is not IDLE
// Optional feature: define PWM_BRIDGE_TIMEOUT_EN to abort a write frame with
// NAK when no byte arrives for TIMEOUT_CYC cycles during GET_DATA.
module pwm_reg_bridge
  import pwm_bridge_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic             rx_ready,
  output logic             tx_valid,
  output logic [7:0]       tx_data,
  input  logic             tx_ready,
  output logic             wr_en,
  output logic             rd_en,
  output logic [3:0]       addr,
  output logic [WIDTH-1:0] wr_data,
  input  logic [WIDTH-1:0] rd_data,
  output logic             busy
);

  localparam int unsigned NB = WIDTH / 8;
  localparam int unsigned CW = (NB > 1) ? $clog2(NB) : 1;

  if ((WIDTH == 0) || ((WIDTH % 8) != 0)) begin : g_bad_width
    $error("pwm_reg_bridge: WIDTH must be a nonzero multiple of 8");
  end
  if (TIMEOUT_CYC == 0) begin : g_bad_timeout
    $error("pwm_reg_bridge: TIMEOUT_CYC must be nonzero");
  end

  state_e           state_q, state_d;
  logic [3:0]       addr_q, addr_d;
  logic [WIDTH-1:0] wr_data_q, wr_data_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             rx_ready_q, rx_ready_d;
  logic             tx_valid_q, tx_valid_d;
  logic             wr_en_q, wr_en_d;
  logic             rd_en_q, rd_en_d;
  logic             busy_q, busy_d;
  logic             rx_hs, tx_hs;
  logic             timeout;

  assign rx_hs = rx_valid && rx_ready_q;
  assign tx_hs = tx_valid_q && tx_ready;

`ifdef PWM_BRIDGE_TIMEOUT_EN
  // Counter restarts on every accepted byte and whenever not collecting data
  pwm_bridge_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (rx_hs || (state_q != GET_DATA)),
    .run_i    (state_q == GET_DATA),
    .expired_o(timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    tx_data_d = tx_data_q;

    case (state_q)
      IDLE: begin
        if (rx_hs) begin
          cnt_d = '0;
          if (rx_data[6:4] != 3'b000) begin
            tx_data_d = RSP_NAK;
            state_d   = SEND;
          end else begin
            addr_d  = rx_data[3:0];
            state_d = rx_data[HDR_W_BIT] ? GET_DATA : READ;
          end
        end
      end
      GET_DATA: begin
        if (timeout) begin
          tx_data_d = RSP_NAK;
          cnt_d     = '0;
          state_d   = SEND;
        end else if (rx_hs) begin
          shift_d = (shift_q << 8) | WIDTH'(rx_data);
          if (cnt_q == CW'(NB - 1)) begin
            // Publish the word only once complete so wr_data is stable in WRITE
            wr_data_d = shift_d;
            state_d   = WRITE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      WRITE: begin
        tx_data_d = RSP_ACK;
        cnt_d     = '0;
        state_d   = SEND;
      end
      READ: begin
        // rd_en is high this cycle; first byte goes straight to tx_data
        tx_data_d = rd_data[WIDTH-1 -: 8];
        shift_d   = rd_data << 8;
        cnt_d     = CW'(NB - 1);
        state_d   = SEND;
      end
      SEND: begin
        if (tx_hs) begin
          if (cnt_q == '0) begin
            state_d = IDLE;
          end else begin
            tx_data_d = shift_q[WIDTH-1 -: 8];
            shift_d   = shift_q << 8;
            cnt_d     = cnt_q - CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it
    rx_ready_d = (state_d == IDLE) || (state_d == GET_DATA);
    tx_valid_d = (state_d == SEND);
    wr_en_d    = (state_d == WRITE);
    rd_en_d    = (state_d == READ);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wr_data_q  <= '0;
      shift_q    <= '0;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      rx_ready_q <= 1'b0;
      tx_valid_q <= 1'b0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wr_data_q  <= wr_data_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      rx_ready_q <= rx_ready_d;
      tx_valid_q <= tx_valid_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      busy_q     <= busy_d;
    end
  end

  assign rx_ready = rx_ready_q;
  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign wr_en    = wr_en_q;
  assign rd_en    = rd_en_q;
  assign addr     = addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_pwm_reg_bridge.sv
// Scoreboard bench for pwm_reg_bridge: stimulus pushes expected bus accesses
// and TX bytes; a negedge monitor pops and compares them as the DUT presents them.
module tb_pwm_reg_bridge;

  localparam int unsigned WIDTH = 16;
`ifdef PWM_BRIDGE_TIMEOUT_EN
  localparam int unsigned TO_CYC = 20;
`else
  localparam int unsigned TO_CYC = 50000;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             rx_valid = 1'b0;
  logic [7:0]       rx_data = 8'h00;
  logic             rx_ready;
  logic             tx_valid;
  logic [7:0]       tx_data;
  logic             tx_ready = 1'b1;
  logic             wr_en, rd_en;
  logic [3:0]       addr;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] rd_val = '0;
  logic             busy;

  always #5 clk = ~clk;

  assign rd_data = rd_en ? rd_val : '0;

  pwm_reg_bridge #(.WIDTH(WIDTH), .TIMEOUT_CYC(TO_CYC)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wr_data(wr_data),
    .rd_data(rd_data), .busy(busy)
  );

  typedef struct packed {
    logic             we;
    logic [3:0]       addr;
    logic [WIDTH-1:0] data;
  } acc_t;

  acc_t       acc_q[$];
  logic [7:0] tx_q[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  int         last_ev = -100;
  bit         lat_en = 1'b1;
  bit         prev_valid = 1'b0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor: scoreboard pops, latency and hold checks
  always @(negedge clk) begin
    acc_t       a;
    logic [7:0] b;
    cyc++;
    if (rst_n) begin
      if (rx_valid && rx_ready) last_ev = cyc;
      if (wr_en || rd_en) begin
        check("strobe_exclusive", 32'(wr_en && rd_en), 32'd0);
        if (acc_q.size() == 0) begin
          flag("unexpected_strobe");
        end else begin
          a = acc_q.pop_front();
          check("acc_we", 32'(wr_en), 32'(a.we));
          check("acc_addr", 32'(addr), 32'(a.addr));
          if (a.we) check("acc_wdata", 32'(wr_data), 32'(a.data));
        end
        if (lat_en) check("strobe_latency", 32'(cyc), 32'(last_ev + 1));
        last_ev = cyc;
      end
      if (tx_valid && !prev_valid && lat_en) check("tx_latency", 32'(cyc), 32'(last_ev + 1));
      if (tx_valid) check("rx_ready_in_send", 32'(rx_ready), 32'd0);
      if (prev_stall) begin
        check("tx_hold_valid", 32'(tx_valid), 32'd1);
        check("tx_hold_data", 32'(tx_data), 32'(prev_data));
      end
      if (tx_valid && tx_ready) begin
        if (tx_q.size() == 0) begin
          flag("unexpected_tx_byte");
        end else begin
          b = tx_q.pop_front();
          check("tx_byte", 32'(tx_data), 32'(b));
        end
      end
      prev_valid = tx_valid;
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end else begin
      prev_valid = 1'b0;
      prev_stall = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    while (!rx_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!rx_ready) flag("rx_accept_timeout");
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    repeat (2) @(negedge clk);
    while ((busy || tx_q.size() != 0) && n < 500) begin
      n++;
      @(negedge clk);
    end
    if (busy || tx_q.size() != 0) flag("idle_wait_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
    check({tag, "_tx_data"},  32'(tx_data),  32'd0);
    check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    check({tag, "_wr_en"},    32'(wr_en),    32'd0);
    check({tag, "_rd_en"},    32'(rd_en),    32'd0);
    check({tag, "_addr"},     32'(addr),     32'd0);
    check({tag, "_wr_data"},  32'(wr_data),  32'd0);
    check({tag, "_busy"},     32'(busy),     32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_rx_ready", 32'(rx_ready), 32'd1);

    // 1. Write 0x1234 to addr 4
    acc_q.push_back('{we: 1'b1, addr: 4'h4, data: 16'h1234});
    tx_q.push_back(8'hA5);
    send_byte(8'h84); send_byte(8'h12); send_byte(8'h34);
    wait_idle();
    check("after_write_busy", 32'(busy), 32'd0);
    check("after_write_wr_data", 32'(wr_data), 32'h1234);

    // 2. Read addr 8 returns 0xBEEF
    rd_val = 16'hBEEF;
    acc_q.push_back('{we: 1'b0, addr: 4'h8, data: '0});
    tx_q.push_back(8'hBE); tx_q.push_back(8'hEF);
    send_byte(8'h08);
    wait_idle();

    // 3. Read with TX backpressure
    rd_val = 16'h1357;
    acc_q.push_back('{we: 1'b0, addr: 4'h3, data: '0});
    tx_q.push_back(8'h13); tx_q.push_back(8'h57);
    tx_ready = 1'b0;
    send_byte(8'h03);
    repeat (2) @(posedge clk);
    #1;
    check("bp_tx_valid", 32'(tx_valid), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    tx_ready = 1'b1;
    @(posedge clk);
    #1;
    tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tx_ready = 1'b1;
    wait_idle();

    // 4. Bad header, then a normal write
    tx_q.push_back(8'h5A);
    send_byte(8'h94);
    wait_idle();
    acc_q.push_back('{we: 1'b1, addr: 4'hF, data: 16'hCAFE});
    tx_q.push_back(8'hA5);
    send_byte(8'h8F); send_byte(8'hCA); send_byte(8'hFE);
    wait_idle();

    // 5. Reset mid-frame, then a fresh write
    send_byte(8'h84); send_byte(8'h12);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    acc_q.push_back('{we: 1'b1, addr: 4'h0, data: 16'h0003});
    tx_q.push_back(8'hA5);
    send_byte(8'h80); send_byte(8'h00); send_byte(8'h03);
    wait_idle();
    check("post_rst_wr_data", 32'(wr_data), 32'h0003);

`ifdef PWM_BRIDGE_TIMEOUT_EN
    // 6. Stalled write frame times out with NAK
    lat_en = 1'b0;
    tx_q.push_back(8'h5A);
    send_byte(8'h8C); send_byte(8'hAA);
    repeat (25) @(posedge clk);
    #1;
    wait_idle();
    lat_en = 1'b1;
`endif

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(acc_q.size() + tx_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
